// File: rtl/vga_glyph_scheduler.sv
// vga_glyph_scheduler
//   Shares one synchronous font ROM (1-cycle read latency) among NUM_SLOTS
//   on-screen character slots. Slot settings are written into shadow
//   registers and copied to the active set on frame_start, so the picture
//   never tears mid-frame. For each pixel the lowest-index enabled slot that
//   covers (x_cnt, y_cnt) wins, its ROM byte address is registered, and the
//   glyph bit is produced three cycles after the counters.
//
// Ports
//   vga_clk, reset      pixel clock, asynchronous active-high reset
//   x_cnt, y_cnt        timing-generator counters (stage 0 inputs)
//   frame_start         one-cycle commit strobe (shadow -> active)
//   cfg_we, cfg_slot    shadow write strobe and slot select
//   cfg_en/x/y/glyph    shadow write data
//   cfg_pending         a shadow write has not been committed yet
//   rom_addr, rom_data  font ROM interface (bit 7 = leftmost pixel)
//   pix_hit/on/slot     pixel result, 3 cycles after x_cnt/y_cnt
//
// There is no handshake: every input is sampled and every output is
// produced once per pixel clock, with fixed latency.
module vga_glyph_scheduler #(
  parameter int NUM_SLOTS     = 4,
  parameter int GLYPH_W       = 56,
  parameter int GLYPH_H       = 75,
  parameter int BYTES_PER_ROW = 7,
  parameter int GLYPH_BYTES   = 525,
  parameter int ROM_AW        = 11
) (
  input  logic              vga_clk,
  input  logic              reset,
  input  logic [10:0]       x_cnt,
  input  logic [9:0]        y_cnt,
  input  logic              frame_start,
  input  logic              cfg_we,
  input  logic [1:0]        cfg_slot,
  input  logic              cfg_en,
  input  logic [10:0]       cfg_x,
  input  logic [9:0]        cfg_y,
  input  logic [1:0]        cfg_glyph,
  output logic              cfg_pending,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [7:0]        rom_data,
  output logic              pix_hit,
  output logic              pix_on,
  output logic [1:0]        pix_slot
);

  // Shadow (written by config port) and active (used for display) slot state.
  logic        sh_en    [NUM_SLOTS];
  logic [10:0] sh_x     [NUM_SLOTS];
  logic [9:0]  sh_y     [NUM_SLOTS];
  logic [1:0]  sh_glyph [NUM_SLOTS];
  logic        act_en   [NUM_SLOTS];
  logic [10:0] act_x    [NUM_SLOTS];
  logic [9:0]  act_y    [NUM_SLOTS];
  logic [1:0]  act_glyph[NUM_SLOTS];

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < NUM_SLOTS; s++) begin
        sh_en[s]     <= 1'b0;
        sh_x[s]      <= '0;
        sh_y[s]      <= '0;
        sh_glyph[s]  <= '0;
        act_en[s]    <= 1'b0;
        act_x[s]     <= '0;
        act_y[s]     <= '0;
        act_glyph[s] <= '0;
      end
      cfg_pending <= 1'b0;
    end else begin
      // Commit copies the pre-edge shadow, so a same-cycle write waits for
      // the next frame_start.
      if (frame_start) begin
        for (int s = 0; s < NUM_SLOTS; s++) begin
          act_en[s]    <= sh_en[s];
          act_x[s]     <= sh_x[s];
          act_y[s]     <= sh_y[s];
          act_glyph[s] <= sh_glyph[s];
        end
      end
      if (cfg_we) begin
        sh_en[cfg_slot]    <= cfg_en;
        sh_x[cfg_slot]     <= cfg_x;
        sh_y[cfg_slot]     <= cfg_y;
        sh_glyph[cfg_slot] <= cfg_glyph;
      end
      if (cfg_we)
        cfg_pending <= 1'b1;
      else if (frame_start)
        cfg_pending <= 1'b0;
    end
  end

  // Stage 0: window test and address formation for every slot. The loop
  // runs from the highest index down so the lowest hitting index is the
  // last assignment and therefore wins.
  logic              hit_s0;
  logic [1:0]        slot_s0;
  logic [ROM_AW-1:0] addr_s0;
  logic [2:0]        bit_s0;
  logic [10:0]       dx;
  logic [9:0]        dy;
  logic [11:0]       x_end;
  logic [10:0]       y_end;
  logic [31:0]       addr_full;

  always_comb begin
    hit_s0    = 1'b0;
    slot_s0   = '0;
    addr_s0   = '0;
    bit_s0    = '0;
    dx        = '0;
    dy        = '0;
    x_end     = '0;
    y_end     = '0;
    addr_full = '0;
    for (int s = NUM_SLOTS - 1; s >= 0; s--) begin
      // One extra bit on the right edge keeps slots near the counter limit
      // from wrapping back to zero.
      x_end = {1'b0, act_x[s]} + 12'(GLYPH_W);
      y_end = {1'b0, act_y[s]} + 11'(GLYPH_H);
      if (act_en[s] &&
          ({1'b0, x_cnt} >= {1'b0, act_x[s]}) && ({1'b0, x_cnt} < x_end) &&
          ({1'b0, y_cnt} >= {1'b0, act_y[s]}) && ({1'b0, y_cnt} < y_end)) begin
        dx        = x_cnt - act_x[s];
        dy        = y_cnt - act_y[s];
        addr_full = 32'(act_glyph[s]) * 32'(GLYPH_BYTES) +
                    32'(dy) * 32'(BYTES_PER_ROW) + 32'(dx[10:3]);
        hit_s0    = 1'b1;
        slot_s0   = s[1:0];
        addr_s0   = addr_full[ROM_AW-1:0];
        bit_s0    = 3'd7 - dx[2:0];
      end
    end
  end

  // Stages 1..3. rom_addr holds on a miss so the ROM is not toggled
  // needlessly; the delayed hit masks whatever it returns.
  logic       hit_s1, hit_s2;
  logic [1:0] slot_s1, slot_s2;
  logic [2:0] bit_s1, bit_s2;

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      rom_addr <= '0;
      hit_s1   <= 1'b0;
      slot_s1  <= '0;
      bit_s1   <= '0;
      hit_s2   <= 1'b0;
      slot_s2  <= '0;
      bit_s2   <= '0;
      pix_hit  <= 1'b0;
      pix_on   <= 1'b0;
      pix_slot <= '0;
    end else begin
      if (hit_s0)
        rom_addr <= addr_s0;
      hit_s1   <= hit_s0;
      slot_s1  <= slot_s0;
      bit_s1   <= bit_s0;
      hit_s2   <= hit_s1;
      slot_s2  <= slot_s1;
      bit_s2   <= bit_s1;
      pix_hit  <= hit_s2;
      pix_slot <= slot_s2;
      pix_on   <= hit_s2 & rom_data[bit_s2];
    end
  end

endmodule

// File: tb/tb_vga_glyph_scheduler.sv
// Bench for vga_glyph_scheduler: directed pixel vectors with hand-computed
// ROM addresses and glyph bits; expectations are queued by the driver and
// popped by a monitor when the delayed pixel-valid tags come out.
module tb_vga_glyph_scheduler;

  logic        vga_clk = 1'b0;
  logic        reset;
  logic [10:0] x_cnt;
  logic [9:0]  y_cnt;
  logic        frame_start;
  logic        cfg_we;
  logic [1:0]  cfg_slot;
  logic        cfg_en;
  logic [10:0] cfg_x;
  logic [9:0]  cfg_y;
  logic [1:0]  cfg_glyph;
  logic        cfg_pending;
  logic [10:0] rom_addr;
  logic [7:0]  rom_data;
  logic        pix_hit;
  logic        pix_on;
  logic [1:0]  pix_slot;

  vga_glyph_scheduler dut (
    .vga_clk     (vga_clk),
    .reset       (reset),
    .x_cnt       (x_cnt),
    .y_cnt       (y_cnt),
    .frame_start (frame_start),
    .cfg_we      (cfg_we),
    .cfg_slot    (cfg_slot),
    .cfg_en      (cfg_en),
    .cfg_x       (cfg_x),
    .cfg_y       (cfg_y),
    .cfg_glyph   (cfg_glyph),
    .cfg_pending (cfg_pending),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .pix_hit     (pix_hit),
    .pix_on      (pix_on),
    .pix_slot    (pix_slot)
  );

  // ---------------- clock / reset / ROM ----------------
  always #5 vga_clk = ~vga_clk;

  logic [7:0] rom [2048];
  always @(posedge vga_clk) rom_data <= rom[rom_addr];

  // ---------------- scoreboard ----------------
  int n_total = 0;
  int n_pass  = 0;
  logic [11:0] addr_q[$];  // {check_enable, expected rom_addr}
  logic [3:0]  pix_q[$];   // {hit, on, slot}

  // Pixel-valid tag delayed to the rom_addr (1) and pix_* (3) latencies.
  logic v0 = 1'b0;
  logic v1, v2, v3;
  always @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      v1 <= 1'b0; v2 <= 1'b0; v3 <= 1'b0;
    end else begin
      v1 <= v0; v2 <= v1; v3 <= v2;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  logic [11:0] ea;
  logic [3:0]  ep;
  always @(negedge vga_clk) begin
    if (!reset && v1) begin
      if (addr_q.size() == 0) begin
        n_total++;
        $display("FAIL addr_q_underflow at %0t", $time);
      end else begin
        ea = addr_q.pop_front();
        if (ea[11]) chk("rom_addr", 32'(rom_addr), 32'(ea[10:0]));
      end
    end
    if (!reset && v3) begin
      if (pix_q.size() == 0) begin
        n_total++;
        $display("FAIL pix_q_underflow at %0t", $time);
      end else begin
        ep = pix_q.pop_front();
        chk("pix_hit",  32'(pix_hit),  32'(ep[3]));
        chk("pix_on",   32'(pix_on),   32'(ep[2]));
        chk("pix_slot", 32'(pix_slot), 32'(ep[1:0]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic px(input int x, input int y, input int chk_a, input int addr,
                    input int hit, input int on, input int slot);
    @(posedge vga_clk); #1;
    x_cnt = 11'(x);
    y_cnt = 10'(y);
    v0    = 1'b1;
    addr_q.push_back({1'(chk_a), 11'(addr)});
    pix_q.push_back({1'(hit), 1'(on), 2'(slot)});
  endtask

  task automatic idle(input int n);
    @(posedge vga_clk); #1;
    v0 = 1'b0;
    repeat (n) @(posedge vga_clk);
    #1;
  endtask

  task automatic cfg(input int slot, input int en, input int x, input int y,
                     input int glyph, input int with_frame);
    @(posedge vga_clk); #1;
    v0          = 1'b0;
    cfg_we      = 1'b1;
    cfg_slot    = 2'(slot);
    cfg_en      = 1'(en);
    cfg_x       = 11'(x);
    cfg_y       = 10'(y);
    cfg_glyph   = 2'(glyph);
    frame_start = 1'(with_frame);
    @(posedge vga_clk); #1;
    cfg_we      = 1'b0;
    frame_start = 1'b0;
  endtask

  task automatic frame();
    @(posedge vga_clk); #1;
    v0          = 1'b0;
    frame_start = 1'b1;
    @(posedge vga_clk); #1;
    frame_start = 1'b0;
  endtask

  task automatic chk_pending(input string name, input logic exp);
    @(negedge vga_clk);
    chk(name, 32'(cfg_pending), 32'(exp));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < 2048; i++) rom[i] = 8'h00;
    rom[0]    = 8'hFF;
    rom[7]    = 8'h01;
    rom[51]   = 8'h01;
    rom[145]  = 8'h80;
    rom[524]  = 8'h01;
    rom[525]  = 8'h80;
    rom[1121] = 8'h20;

    reset = 1'b1; x_cnt = '0; y_cnt = '0; frame_start = 1'b0;
    cfg_we = 1'b0; cfg_slot = '0; cfg_en = 1'b0; cfg_x = '0; cfg_y = '0; cfg_glyph = '0;
    repeat (3) @(posedge vga_clk);
    @(negedge vga_clk);
    chk("rst_pending",  32'(cfg_pending), 0);
    chk("rst_rom_addr", 32'(rom_addr),    0);
    chk("rst_pix_hit",  32'(pix_hit),     0);
    chk("rst_pix_on",   32'(pix_on),      0);
    chk("rst_pix_slot", 32'(pix_slot),    0);
    @(posedge vga_clk); #1;
    reset = 1'b0;

    // Sparse frame sweep with nothing configured: no hit, address stays 0.
    for (int y = 0; y < 628; y += 57)
      for (int x = 0; x < 1056; x += 48)
        px(x, y, 1, 0, 0, 0, 0);
    frame();
    idle(4);
    chk_pending("sweep_pending", 1'b0);

    // Slot 0 at (500,300), glyph 0; invisible until committed.
    cfg(0, 1, 500, 300, 0, 0);
    chk_pending("wr0_pending", 1'b1);
    px(500, 300, 1, 0, 0, 0, 0);
    frame();
    chk_pending("commit0_pending", 1'b0);
    px(500, 300, 1, 0,   1, 1, 0);
    px(501, 300, 1, 0,   1, 1, 0);
    px(508, 300, 1, 1,   1, 0, 0);
    px(500, 301, 1, 7,   1, 0, 0);
    px(507, 301, 1, 7,   1, 1, 0);
    px(555, 374, 1, 524, 1, 1, 0);
    px(556, 300, 1, 524, 0, 0, 0);  // right edge, address holds
    px(500, 375, 1, 524, 0, 0, 0);  // bottom edge
    px(499, 300, 1, 524, 0, 0, 0);
    px(500, 299, 1, 524, 0, 0, 0);

    // Slot 1 glyph 1, slot 2 glyph 2 overlapping slot 0.
    cfg(1, 1, 650, 300, 1, 0);
    cfg(2, 1, 510, 310, 2, 0);
    frame();
    for (int x = 650; x <= 657; x++)
      px(x, 300, 1, 525, 1, (x == 650) ? 1 : 0, 1);
    px(520, 320, 1, 142,  1, 0, 0);  // slot 0 beats slot 2
    px(565, 320, 1, 1126, 1, 0, 2);
    cfg(0, 0, 500, 300, 0, 0);
    frame();
    px(520, 320, 1, 1121, 1, 1, 2);

    // Write in the same cycle as frame_start stays in shadow.
    cfg(3, 1, 100, 100, 3, 1);
    chk_pending("samecyc_pending", 1'b1);
    px(100, 100, 1, 1121, 0, 0, 0);
    frame();
    chk_pending("samecyc_commit_pending", 1'b0);
    px(100, 100, 1, 1575, 1, 0, 3);
    px(155, 100, 1, 1581, 1, 0, 3);
    px(155, 174, 1, 51,   1, 1, 3);  // 2099 truncated to 11 bits
    px(156, 100, 1, 51,   0, 0, 0);
    px(100, 175, 1, 51,   0, 0, 0);

    // Slot extending past the visible line end.
    cfg(3, 1, 1000, 500, 1, 0);
    frame();
    px(1055, 500, 1, 531, 1, 0, 3);
    px(1047, 501, 1, 537, 1, 0, 3);
    px(999,  500, 1, 537, 0, 0, 0);

    // Slot near the counter limits: edge sums must not wrap.
    cfg(3, 1, 2000, 1000, 0, 0);
    frame();
    px(2040, 1020, 1, 145, 1, 1, 3);
    px(2047, 1020, 1, 145, 1, 0, 3);
    px(10,   1020, 1, 145, 0, 0, 0);
    px(2040, 50,   1, 145, 0, 0, 0);
    idle(5);

    // Reset in the middle of a lit glyph pixel.
    x_cnt = 11'd650;
    y_cnt = 10'd300;
    repeat (4) @(posedge vga_clk);
    @(negedge vga_clk);
    chk("pre_rst_hit",  32'(pix_hit),  1);
    chk("pre_rst_on",   32'(pix_on),   1);
    chk("pre_rst_slot", 32'(pix_slot), 1);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_hit",  32'(pix_hit),  0);
    chk("async_rst_on",   32'(pix_on),   0);
    chk("async_rst_slot", 32'(pix_slot), 0);
    chk("async_rst_addr", 32'(rom_addr), 0);
    @(posedge vga_clk); #1;
    reset = 1'b0;
    frame();
    px(650, 300, 1, 0, 0, 0, 0);
    px(500, 300, 1, 0, 0, 0, 0);
    idle(5);
    chk_pending("post_rst_pending", 1'b0);

    // Bounded drain of any outstanding expectations.
    for (int i = 0; i < 20 && (addr_q.size() != 0 || pix_q.size() != 0); i++)
      @(posedge vga_clk);
    if (addr_q.size() != 0 || pix_q.size() != 0) begin
      n_total++;
      $display("FAIL drain: got %0d/%0d entries left expected 0", addr_q.size(), pix_q.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
